// File: rtl/stq_wb_pkg.sv
// Shared types and width helpers for the store-queue write-back master.
// Also provides the default line width when STQ_DATA_WIDTH is not
// supplied on the command line.
`ifndef STQ_DATA_WIDTH
`define STQ_DATA_WIDTH 512
`endif

package stq_wb_pkg;

    // Job-level FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } stq_wb_state_t;

    localparam int unsigned STQ_WB_DEF_FIFO_DEPTH      = 4;
    localparam int unsigned STQ_WB_DEF_MAX_OUTSTANDING = 8;

    // Widths for the default configuration
    localparam int unsigned STQ_WB_PTR_W = $clog2(STQ_WB_DEF_FIFO_DEPTH);
    localparam int unsigned STQ_WB_OUT_W = $clog2(STQ_WB_DEF_MAX_OUTSTANDING + 1);

    // FIFO pointer width for an arbitrary power-of-two depth
    function automatic int unsigned stq_wb_ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Outstanding counter width, wide enough to hold max_out itself
    function automatic int unsigned stq_wb_out_w(input int unsigned max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/stq_wb_fifo.sv
// Line buffer for the write-back master: synchronous FIFO with a
// registered storage array (no fall-through), full/empty flags and a
// flush that empties it when a new job starts.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               drop all contents (pointers/count cleared)
//   push, push_data     write one line (ignored when full)
//   pop                 drop the head line (ignored when empty)
//   head                current head line
//   full, empty         occupancy flags
module stq_wb_fifo
    import stq_wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned PTR_W = stq_wb_ptr_w(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Storage and pointers; depth is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/stq_wb_master.sv
// Write-back master behind the store-queue interface. Buffers incoming
// result lines, issues them as sequential-address write requests, bounds
// unacknowledged writes, and signals done once the whole job is written
// and acknowledged.
// Optional feature macro: STQ_WB_PERF_CNT_EN adds stall counters
// perf_in_stall / perf_out_stall.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, base_addr, num_lines   job launch (sampled in IDLE/DONE)
//   stq_valid, stq_data, stq_ready  upstream line handshake
//   wr_valid, wr_addr, wr_data, wr_ready  write request handshake
//   wr_ack                        one pulse per completed write
//   busy, done                    job status
`ifndef STQ_DATA_WIDTH
`define STQ_DATA_WIDTH 512
`endif

module stq_wb_master
    import stq_wb_pkg::*;
#(
    parameter int unsigned STQ_DATA_WIDTH  = `STQ_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned LINE_BYTES      = STQ_DATA_WIDTH / 8,
    parameter int unsigned FIFO_DEPTH      = STQ_WB_DEF_FIFO_DEPTH,
    parameter int unsigned MAX_OUTSTANDING = STQ_WB_DEF_MAX_OUTSTANDING,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    input  logic [CNT_WIDTH-1:0]      num_lines,
    input  logic                      stq_valid,
    input  logic [STQ_DATA_WIDTH-1:0] stq_data,
    output logic                      stq_ready,
    output logic                      wr_valid,
    output logic [ADDR_WIDTH-1:0]     wr_addr,
    output logic [STQ_DATA_WIDTH-1:0] wr_data,
    input  logic                      wr_ready,
    input  logic                      wr_ack,
    output logic                      busy,
    output logic                      done
`ifdef STQ_WB_PERF_CNT_EN
    ,
    output logic [31:0]               perf_in_stall,
    output logic [31:0]               perf_out_stall
`endif
);

    localparam int unsigned OUT_W = stq_wb_out_w(MAX_OUTSTANDING);

    stq_wb_state_t          state_q;
    stq_wb_state_t          state_d;

    logic [CNT_WIDTH-1:0]   num_q;
    logic [CNT_WIDTH-1:0]   in_cnt_q;
    logic [CNT_WIDTH-1:0]   out_cnt_q;
    logic [CNT_WIDTH-1:0]   ack_cnt_q;
    logic [OUT_W-1:0]       outstanding_q;
    logic [OUT_W-1:0]       outstanding_d;
    logic [ADDR_WIDTH-1:0]  addr_q;

    logic                   start_ok;
    logic                   job_go;
    logic                   in_hs;
    logic                   wr_hs;
    logic                   ack_ok;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign job_go   = start_ok && (num_lines != '0);
    assign in_hs    = stq_valid && stq_ready;
    assign wr_hs    = wr_valid && wr_ready;
    // Acks with nothing outstanding are stray and dropped
    assign ack_ok   = wr_ack && (outstanding_q != '0);

    assign wr_addr  = addr_q;

    stq_wb_fifo #(
        .DATA_WIDTH (STQ_DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (job_go),
        .push      (in_hs),
        .push_data (stq_data),
        .pop       (wr_hs),
        .head      (wr_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Outstanding write tracking; simultaneous issue and ack cancel
    always_comb begin
        outstanding_d = outstanding_q;
        if (wr_hs && !ack_ok) begin
            outstanding_d = outstanding_q + OUT_W'(1);
        end else if (!wr_hs && ack_ok) begin
            outstanding_d = outstanding_q - OUT_W'(1);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DRAIN exit looks at the post-ack outstanding count
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d = (num_lines == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_cnt_q == num_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((out_cnt_q == num_q) && (outstanding_d == '0)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from registered state and counters
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        stq_ready = 1'b0;
        wr_valid  = 1'b0;
        if ((state_q == ST_RUN) || (state_q == ST_DRAIN)) begin
            busy     = 1'b1;
            wr_valid = !fifo_empty && (outstanding_q < OUT_W'(MAX_OUTSTANDING));
        end
        if (state_q == ST_DONE) begin
            done = 1'b1;
        end
        if (state_q == ST_RUN) begin
            stq_ready = !fifo_full && (in_cnt_q < num_q);
        end
    end

    // Job counters and running write address
    always_ff @(posedge clk) begin
        if (rst) begin
            num_q         <= '0;
            in_cnt_q      <= '0;
            out_cnt_q     <= '0;
            ack_cnt_q     <= '0;
            outstanding_q <= '0;
            addr_q        <= '0;
        end else if (job_go) begin
            num_q         <= num_lines;
            in_cnt_q      <= '0;
            out_cnt_q     <= '0;
            ack_cnt_q     <= '0;
            outstanding_q <= '0;
            addr_q        <= base_addr;
        end else begin
            if (in_hs) begin
                in_cnt_q <= in_cnt_q + CNT_WIDTH'(1);
            end
            if (wr_hs) begin
                out_cnt_q <= out_cnt_q + CNT_WIDTH'(1);
                addr_q    <= addr_q + ADDR_WIDTH'(LINE_BYTES);
            end
            if (ack_ok) begin
                ack_cnt_q <= ack_cnt_q + CNT_WIDTH'(1);
            end
            outstanding_q <= outstanding_d;
        end
    end

`ifdef STQ_WB_PERF_CNT_EN
    // Saturating stall counters, cleared on every accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_in_stall  <= '0;
            perf_out_stall <= '0;
        end else if (start_ok) begin
            perf_in_stall  <= '0;
            perf_out_stall <= '0;
        end else begin
            if ((state_q == ST_RUN) && stq_valid && !stq_ready && (perf_in_stall != '1)) begin
                perf_in_stall <= perf_in_stall + 32'd1;
            end
            if (wr_valid && !wr_ready && (perf_out_stall != '1)) begin
                perf_out_stall <= perf_out_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stq_wb_master.sv
// Self-checking bench for stq_wb_master: randomized traffic compared each
// cycle against a queue-based job model, plus directed scenarios.
`ifndef STQ_DATA_WIDTH
`define STQ_DATA_WIDTH 512
`endif

module tb_stq_wb_master;

    localparam int unsigned DW      = `STQ_DATA_WIDTH;
    localparam int unsigned AW      = 32;
    localparam int unsigned LB      = DW / 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MAX_OUT = 8;
    localparam int unsigned CW      = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] num_lines = '0;
    logic          stq_valid = 1'b0;
    logic [DW-1:0] stq_data = '0;
    logic          stq_ready;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready = 1'b0;
    logic          wr_ack = 1'b0;
    logic          busy;
    logic          done;
`ifdef STQ_WB_PERF_CNT_EN
    logic [31:0]   perf_in_stall;
    logic [31:0]   perf_out_stall;
`endif

    stq_wb_master #(
        .STQ_DATA_WIDTH  (DW),
        .ADDR_WIDTH      (AW),
        .LINE_BYTES      (LB),
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAX_OUT),
        .CNT_WIDTH       (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_lines (num_lines),
        .stq_valid (stq_valid),
        .stq_data  (stq_data),
        .stq_ready (stq_ready),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .wr_ack    (wr_ack),
        .busy      (busy),
        .done      (done)
`ifdef STQ_WB_PERF_CNT_EN
        ,
        .perf_in_stall  (perf_in_stall),
        .perf_out_stall (perf_out_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus knobs (percent probabilities)
    int v_pct = 100;
    int r_pct = 100;
    int a_pct = 100;

    // Reference model: job phase 0=idle 1=run 2=drain 3=done
    int            m_phase = 0;
    int            m_num   = 0;
    int            m_in    = 0;
    int            m_out   = 0;
    int            m_outst = 0;
    logic [AW-1:0] m_base  = '0;
    logic [DW-1:0] m_q[$];
    int            m_pin   = 0;
    int            m_pout  = 0;

    // Observations of the DUT for the current job
    int            obs_acc = 0;
    int            obs_hs  = 0;
    logic [AW-1:0] obs_addr[$];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check this cycle against the model, advance the model, then drive next inputs
    task automatic step();
        logic          e_busy, e_done, e_srdy, e_wv, acc, hs, ackv;
        logic [AW-1:0] e_addr;
        int            old_in, old_out;
        @(negedge clk);
        e_busy = (m_phase == 1) || (m_phase == 2);
        e_done = (m_phase == 3);
        e_srdy = (m_phase == 1) && (m_q.size() < DEPTH) && (m_in < m_num);
        e_wv   = e_busy && (m_q.size() > 0) && (m_outst < MAX_OUT);
        chk("stq_ready", stq_ready, e_srdy);
        chk("wr_valid", wr_valid, e_wv);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        if (e_wv) begin
            e_addr = m_base + AW'(m_out * LB);
            chk("wr_addr", wr_addr, e_addr);
            chk("wr_data", wr_data, m_q[0]);
        end
`ifdef STQ_WB_PERF_CNT_EN
        chk("perf_in_stall", perf_in_stall, m_pin);
        chk("perf_out_stall", perf_out_stall, m_pout);
`endif
        if (stq_valid && stq_ready) obs_acc++;
        if (wr_valid && wr_ready) begin
            obs_hs++;
            obs_addr.push_back(wr_addr);
        end

        acc  = e_srdy && stq_valid;
        hs   = e_wv && wr_ready;
        ackv = wr_ack && (m_outst > 0);
        if (rst) begin
            m_phase = 0; m_in = 0; m_out = 0; m_outst = 0;
            m_q.delete(); m_pin = 0; m_pout = 0;
        end else if (m_phase == 0 || m_phase == 3) begin
            if (start) begin
                m_pin = 0; m_pout = 0;
                if (num_lines == 0) begin
                    m_phase = 3;
                end else begin
                    m_phase = 1; m_base = base_addr; m_num = int'(num_lines);
                    m_in = 0; m_out = 0; m_outst = 0; m_q.delete();
                end
            end
        end else begin
            old_in  = m_in;
            old_out = m_out;
            if (m_phase == 1 && stq_valid && !e_srdy) m_pin++;
            if (e_wv && !wr_ready) m_pout++;
            if (acc) begin
                m_q.push_back(stq_data);
                m_in++;
            end
            if (hs) begin
                void'(m_q.pop_front());
                m_out++;
            end
            m_outst = m_outst + (hs ? 1 : 0) - (ackv ? 1 : 0);
            if (m_phase == 1 && old_in == m_num) m_phase = 2;
            else if (m_phase == 2 && old_out == m_num && m_outst == 0) m_phase = 3;
        end

        @(posedge clk);
        #1;
        start     = 1'b0;
        stq_valid = ($urandom_range(99) < v_pct);
        wr_ready  = ($urandom_range(99) < r_pct);
        wr_ack    = ($urandom_range(99) < a_pct);
        for (int i = 0; i < int'(DW / 32); i++) stq_data[i*32 +: 32] = $urandom;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic launch(input logic [AW-1:0] base, input int n);
        start     = 1'b1;
        base_addr = base;
        num_lines = CW'(n);
        obs_acc   = 0;
        obs_hs    = 0;
        obs_addr.delete();
        step();
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000 && m_phase != 3; i++) step();
        if (m_phase != 3) chk({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        // Reset
        steps(3);
        rst = 1'b0;
        chk("rst_stq_ready", stq_ready, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        steps(2);

        // Full rate, 4 lines
        v_pct = 100; r_pct = 100; a_pct = 100;
        launch(32'h1000, 4);
        wait_done("basic");
        chk("basic_count", obs_hs, 4);
        if (obs_addr.size() == 4) begin
            chk("basic_a0", obs_addr[0], 32'h1000);
            chk("basic_a1", obs_addr[1], 32'h1040);
            chk("basic_a2", obs_addr[2], 32'h1080);
            chk("basic_a3", obs_addr[3], 32'h10C0);
        end
        steps(2);

        // Write side back-pressured for 10 cycles
        v_pct = 100; r_pct = 0; a_pct = 100;
        launch(32'h2000, 8);
        steps(10);
        chk("bp_accepted", obs_acc, 4);
        chk("bp_stq_ready", stq_ready, 0);
        r_pct = 100;
        wait_done("bp");
        chk("bp_count", obs_hs, 8);

        // Acks withheld, 12 lines
        v_pct = 100; r_pct = 100; a_pct = 0;
        launch(32'h3000, 12);
        steps(30);
        chk("noack_issued", obs_hs, 8);
        chk("noack_wr_valid", wr_valid, 0);
        a_pct = 100;
        wait_done("noack");
        chk("noack_count", obs_hs, 12);

        // Zero-length job, then start ignored during RUN
        v_pct = 30; r_pct = 100; a_pct = 60;
        launch(32'h4000, 0);
        chk("zero_done", done, 1);
        chk("zero_wr_valid", wr_valid, 0);
        launch(32'h5000, 5);
        steps(2);
        start = 1'b1; base_addr = 32'h0; num_lines = CW'(2);
        step();
        wait_done("ign");
        chk("ign_count", obs_hs, 5);
        if (obs_addr.size() == 5) chk("ign_last_addr", obs_addr[4], 32'h5100);

        // Reset mid-job after 3 of 6 lines, then a wrapping job
        v_pct = 100; r_pct = 100; a_pct = 100;
        launch(32'h6000, 6);
        for (int i = 0; i < 20 && obs_acc < 3; i++) step();
        chk("mid_acc", obs_acc, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_stq_ready", stq_ready, 0);
        chk("mid_wr_valid", wr_valid, 0);
        chk("mid_wr_addr", wr_addr, 0);
        chk("mid_wr_data", wr_data, 0);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        steps(2);
        launch(32'hFFFF_FFC0, 2);
        wait_done("wrap");
        chk("wrap_count", obs_hs, 2);
        if (obs_addr.size() == 2) begin
            chk("wrap_a0", obs_addr[0], 32'hFFFF_FFC0);
            chk("wrap_a1", obs_addr[1], 32'h0);
        end

`ifdef STQ_WB_PERF_CNT_EN
        // Five stalled request cycles
        v_pct = 100; r_pct = 0; a_pct = 100;
        launch(32'h7000, 2);
        steps(6);
        chk("perf_out_5", perf_out_stall, 5);
        wr_ready = 1'b1;
        r_pct = 100;
        wait_done("perf");
`endif

        // Randomized jobs
        for (int j = 0; j < 8; j++) begin
            int n;
            v_pct = $urandom_range(100, 20);
            r_pct = $urandom_range(100, 20);
            a_pct = $urandom_range(100, 20);
            n     = $urandom_range(20, 1);
            launch($urandom, n);
            wait_done("rand");
            chk("rand_count", obs_hs, n);
            steps($urandom_range(3, 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stq_wb_master.md
# stq_wb_master

Write-back master directly downstream of the store-queue interface. Accepts packed result lines (one output value per unit) over the `stq_valid`/`stq_ready` handshake and buffers them in a small FIFO. Issues each line as a sequential-address memory write request, tracks outstanding write acknowledgements, and raises `done` once every line of the job is written and acknowledged.

## Interface
- `STQ_DATA_WIDTH`, default `` `STQ_DATA_WIDTH ``: width of one result line and of `wr_data`.
- `ADDR_WIDTH`, default 32: byte-address width.
- `LINE_BYTES`, default `STQ_DATA_WIDTH/8`: address stride per line; must be a power of two.
- `FIFO_DEPTH`, default 4: line buffer depth; power of two, ≥2.
- `MAX_OUTSTANDING`, default 8: maximum number of unacknowledged writes.
- `CNT_WIDTH`, default 16: width of line counters.
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: single-cycle pulse that launches a job; sampled only in IDLE or DONE.
- `base_addr` in ADDR_WIDTH: first write address; captured on `start`.
- `num_lines` in CNT_WIDTH: number of lines in the job; captured on `start`.
- `stq_valid` in 1: upstream line valid.
- `stq_data` in STQ_DATA_WIDTH: upstream line.
- `stq_ready` out 1: line accepted when `stq_valid && stq_ready`.
- `wr_valid` out 1: write request valid.
- `wr_addr` out ADDR_WIDTH: write byte address.
- `wr_data` out STQ_DATA_WIDTH: write payload.
- `wr_ready` in 1: request accepted when `wr_valid && wr_ready`.
- `wr_ack` in 1: one pulse per completed write.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: high in DONE.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset state is IDLE.
- IDLE or DONE, `start`:
  - `start` with `num_lines==0` goes to DONE.
  - Otherwise go to RUN. Capture `base_addr` and `num_lines`; clear `in_cnt`, `out_cnt`, `ack_cnt` and the FIFO.
- RUN: `stq_ready = !fifo_full && (in_cnt < num_lines)`. Each accepted line is pushed to the FIFO and increments `in_cnt`.
- Request side, independent of the input side:
  - `wr_valid = !fifo_empty && (outstanding < MAX_OUTSTANDING)`.
  - `wr_data` is the FIFO head.
  - `wr_addr = base + out_cnt*LINE_BYTES`, implemented as a running address register incremented by `LINE_BYTES` on each request handshake.
  - A request handshake pops the FIFO and increments `out_cnt`.
- `outstanding` counts +1 on a request handshake and −1 on `wr_ack`. Both in the same cycle leave it unchanged.
- A `wr_ack` arriving while `outstanding==0` is a protocol error. Ignore it; `outstanding` does not underflow.
- RUN goes to DRAIN when `in_cnt==num_lines`.
- DRAIN goes to DONE when `out_cnt==num_lines` and `outstanding==0`, including the last ack arriving in that same cycle.
- DONE holds until the next `start` or `rst`.
- `start` during RUN or DRAIN is ignored.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap is silent.

## Timing
- Reset values:
  - `stq_ready`=0, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0.
  - All counters 0; FIFO empty.
- `rst` asserted mid-job returns to IDLE on the next edge. FIFO contents and counts are discarded; no further requests are issued.
- Latency: a line accepted at edge N is presented on `wr_valid` from cycle N+1 (registered FIFO, no fall-through).
- `wr_valid`, `wr_addr` and `wr_data` hold stable until `wr_ready` is seen.
- Full-rate operation: one line in and one request out per cycle. A simultaneous push and pop while full is not allowed, because `stq_ready` is computed from `fifo_full`.
- `stq_ready` does not depend combinationally on `stq_valid`.
- `done` rises one cycle after the final ack is sampled.

## Configuration
- `STQ_WB_PERF_CNT_EN` defined adds outputs `perf_in_stall` [31:0] and `perf_out_stall` [31:0]. Both clear on `start` and saturate at all-ones.
  - `perf_in_stall` counts RUN cycles with `stq_valid && !stq_ready`.
  - `perf_out_stall` counts cycles with `wr_valid && !wr_ready`.
- Undefined: these ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package `stq_wb_pkg` holds:
  - FSM state enum `stq_wb_state_t`.
  - Localparams deriving pointer width (`$clog2(FIFO_DEPTH)`) and outstanding-counter width (`$clog2(MAX_OUTSTANDING+1)`).
- One sub-module, `stq_wb_fifo`: synchronous, registered output, with `full` and `empty` flags and a flush on `start`. The FSM, counters and address generation live in the top module.

## Test plan
- `base_addr=0x1000`, `num_lines=4`, `LINE_BYTES=64`, `wr_ready` and `wr_ack` always 1 -> writes to 0x1000, 0x1040, 0x1080, 0x10C0 in order, data matches input; `done` rises 1 cycle after the 4th ack.
- `wr_ready=0` for 10 cycles, upstream always valid -> exactly 4 lines accepted, then `stq_ready=0`; request held stable; no loss or duplication after release.
- `wr_ack` withheld, 12 lines -> at most 8 requests issued; remaining requests resume one per ack.
- `num_lines=0` with `start` -> DONE next cycle, no `wr_valid`; `start` during RUN is ignored.
- `rst` mid-job after 3 of 6 lines -> all outputs at reset values next cycle; a fresh 2-line job at 0xFFFFFFC0 completes with the second address wrapped to 0x00000000.
- With `STQ_WB_PERF_CNT_EN`: 5 cycles of `wr_ready` low while `wr_valid` is high -> `perf_out_stall==5`.
